async_sram_target: RTL
======================

ASYNC_SRAM_TARGET -- requirements
Module: async_sram_target

Interface
REQ-001 Parameter W_ADDR, default 18, pad and memory address width.
REQ-002 Parameter W_DATA, default 16, data width; SHALL be a multiple of 8, W_DATA/8 byte lanes.
REQ-003 clk  in  1  single clock for all logic; pads are asynchronous to it.
REQ-004 rst  in  1  reset, asynchronous assert, active-high.
REQ-005 pad_addr  in  W_ADDR  address from external host.
REQ-006 pad_ce_n / pad_we_n / pad_oe_n  in  1 each  host chip enable, write enable, output enable, active-low.
REQ-007 pad_byte_n  in  W_DATA/8  host byte-lane enables, active-low.
REQ-008 pad_dq_in  in  W_DATA  data from pad; pad_dq_out  out  W_DATA  data to pad; pad_dq_oe  out  W_DATA  per-bit output enable (tristate triple kept to top level).
REQ-009 mem_addr  out  W_ADDR  internal synchronous SRAM address.
REQ-010 mem_ren  out  1  read strobe; mem_rdata  in  W_DATA  valid one cycle after mem_ren.
REQ-011 mem_wen  out  W_DATA/8  per-byte write strobe; mem_wdata  out  W_DATA.

Function
REQ-012 All pad inputs SHALL pass through 2-flop synchronizers; all logic uses synchronized values only ("s_" below).
REQ-013 Synchronizer reset values: s_ce_n, s_we_n, s_oe_n = 1; s_byte_n all 1; s_addr, s_dq = 0.
REQ-014 A registered copy of s_addr from the previous cycle SHALL be kept; address is "stable" when s_addr equals that copy.
REQ-015 FSM states: IDLE, RD_REQ, RD_DRIVE, WR_HOLD, WR_COMMIT.
REQ-016 IDLE -> WR_HOLD when s_ce_n=0 and s_we_n=0 (takes priority over read).
REQ-017 IDLE -> RD_REQ when s_ce_n=0, s_oe_n=0, s_we_n=1 and address stable.
REQ-018 RD_REQ: mem_ren=1, mem_addr=s_addr for exactly one cycle, then -> RD_DRIVE.
REQ-019 Entering RD_DRIVE SHALL register mem_rdata into pad_dq_out and set pad_dq_oe for byte lanes with s_byte_n=0, all 8 bits of each enabled lane.
REQ-020 In RD_DRIVE, lane enables SHALL track s_byte_n each cycle; an address change (s_addr differs from the address read) SHALL return to IDLE with pad_dq_oe cleared that same cycle, re-reading once stable.
REQ-021 RD_DRIVE -> IDLE when s_ce_n=1 or s_oe_n=1; pad_dq_oe cleared at that clock edge.
REQ-022 RD_DRIVE -> WR_HOLD when s_we_n=0 and s_ce_n=0; pad_dq_oe cleared at that edge (contention guard).
REQ-023 Latency: from read conditions becoming true at pad inputs, pad_dq_oe SHALL assert after at most 6 rising clk edges; host access time SHALL be specified at 7 clk periods.
REQ-024 WR_HOLD: every cycle latch s_addr, s_dq, s_byte_n into hold registers; pad_dq_oe=0.
REQ-025 WR_HOLD -> WR_COMMIT when s_we_n=1 or s_ce_n=1; hold registers NOT updated on that cycle.
REQ-026 WR_COMMIT: one cycle, mem_addr=held address, mem_wdata=held data, mem_wen[i]=~held byte_n[i]; then -> IDLE.
REQ-027 Write with all held byte_n=1 SHALL commit with mem_wen=0 (no memory change), still passing WR_COMMIT.
REQ-028 Host write timing: addr/data/byte_n setup to we_n rise >=3 clk periods, hold >=1 clk period; we_n low >=3 clk periods.
REQ-029 Read immediately after write (same address) SHALL return the new data, because WR_COMMIT precedes any RD_REQ.
REQ-030 mem_ren and mem_wen SHALL never be asserted in the same cycle.
REQ-031 pad_dq_out SHALL hold its last value when pad_dq_oe=0.

Reset
REQ-032 On rst: state IDLE, pad_dq_oe=0, pad_dq_out=0, mem_ren=0, mem_wen=0, mem_addr=0, mem_wdata=0, hold registers 0, synchronizers per REQ-013.
REQ-033 rst asserted mid-write SHALL discard the pending write (no mem_wen after release); mid-read SHALL release pad drive immediately (asynchronously).
REQ-034 After rst release, no access starts until two clk edges have refreshed the synchronizers.

Verification
REQ-035 Read: mem holds 0xBEEF at 0x00123; host ce_n=0, oe_n=0, we_n=1, byte_n=00, addr=0x00123 -> pad_dq_oe=0xFFFF, pad_dq_out=0xBEEF within 6 edges; oe_n=1 -> oe cleared.
REQ-036 Write: addr=0x00010, dq=0x1234, byte_n=10, we_n pulse 4 clk -> one mem_wen=01, mem_wdata=0x1234, mem_addr=0x00010; readback returns 0x34 in low byte, upper byte unchanged.
REQ-037 Address walk during read: addr 0x1 -> 0x2 with oe_n held low -> oe drops, second mem_ren at 0x2, pad_dq_out updates to mem[0x2].
REQ-038 Contention: we_n falls while driving -> pad_dq_oe=0 within 3 edges, subsequent write commits normally.
REQ-039 Reset mid-write: rst pulsed while we_n=0 -> no mem_wen ever issued for that access; all outputs at reset values.
REQ-040 Random host accesses at minimum timing vs. reference memory model: no mismatch, mem_ren/mem_wen never concurrent.

Source files
------------

// File: rtl/async_sram_target.sv
// Async SRAM host-pad target bridging an external asynchronous SRAM-style
// host onto an internal single-cycle synchronous SRAM port.
//   clk, rst                      : single clock, async active-high reset
//   pad_addr/ce_n/we_n/oe_n       : host address and strobes (active-low)
//   pad_byte_n                    : host byte-lane enables (active-low)
//   pad_dq_in/out/oe              : pad data tristate triple (per-bit oe)
//   mem_addr/ren/rdata            : synchronous read port, rdata one cycle after ren
//   mem_wen/wdata                 : per-byte synchronous write port
module async_sram_target #(
  parameter int unsigned W_ADDR = 18,
  parameter int unsigned W_DATA = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W_ADDR-1:0]   pad_addr,
  input  logic                pad_ce_n,
  input  logic                pad_we_n,
  input  logic                pad_oe_n,
  input  logic [W_DATA/8-1:0] pad_byte_n,
  input  logic [W_DATA-1:0]   pad_dq_in,
  output logic [W_DATA-1:0]   pad_dq_out,
  output logic [W_DATA-1:0]   pad_dq_oe,
  output logic [W_ADDR-1:0]   mem_addr,
  output logic                mem_ren,
  input  logic [W_DATA-1:0]   mem_rdata,
  output logic [W_DATA/8-1:0] mem_wen,
  output logic [W_DATA-1:0]   mem_wdata
);

  localparam int unsigned NB = W_DATA / 8;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DRIVE, WR_HOLD, WR_COMMIT} state_t;

  state_t            state_q, state_d;
  logic              m_ce_n_q, m_we_n_q, m_oe_n_q;
  logic              s_ce_n_q, s_we_n_q, s_oe_n_q;
  logic [NB-1:0]     m_byte_n_q, s_byte_n_q;
  logic [W_ADDR-1:0] m_addr_q, s_addr_q;
  logic [W_DATA-1:0] m_dq_q, s_dq_q;
  logic [W_ADDR-1:0] addr_prev_q;
  logic [W_ADDR-1:0] rd_addr_q, rd_addr_d;
  logic              rd_live_q, rd_live_d;
  logic [W_ADDR-1:0] hold_addr_q, hold_addr_d;
  logic [W_DATA-1:0] hold_data_q, hold_data_d;
  logic [NB-1:0]     hold_byte_n_q, hold_byte_n_d;
  logic [W_DATA-1:0] pad_dq_out_q, pad_dq_out_d;
  logic [W_DATA-1:0] pad_dq_oe_q, pad_dq_oe_d;
  logic [W_ADDR-1:0] mem_addr_q, mem_addr_d;
  logic              mem_ren_q, mem_ren_d;
  logic [NB-1:0]     mem_wen_q, mem_wen_d;
  logic [W_DATA-1:0] mem_wdata_q, mem_wdata_d;
  logic [W_DATA-1:0] lane_oe;
  logic              addr_stable;

  assign addr_stable = (s_addr_q == addr_prev_q);

  always_comb begin
    lane_oe = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      lane_oe[i*8 +: 8] = {8{~s_byte_n_q[i]}};
    end
  end

  always_comb begin
    state_d       = state_q;
    rd_addr_d     = rd_addr_q;
    rd_live_d     = rd_live_q;
    hold_addr_d   = hold_addr_q;
    hold_data_d   = hold_data_q;
    hold_byte_n_d = hold_byte_n_q;
    pad_dq_out_d  = pad_dq_out_q;
    pad_dq_oe_d   = '0;
    mem_addr_d    = mem_addr_q;
    mem_ren_d     = 1'b0;
    mem_wen_d     = '0;
    mem_wdata_d   = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (!s_ce_n_q && !s_we_n_q) begin
          state_d       = WR_HOLD;
          hold_addr_d   = s_addr_q;
          hold_data_d   = s_dq_q;
          hold_byte_n_d = s_byte_n_q;
        end else if (!s_ce_n_q && !s_oe_n_q && addr_stable) begin
          state_d    = RD_REQ;
          mem_ren_d  = 1'b1;
          mem_addr_d = s_addr_q;
          rd_addr_d  = s_addr_q;
        end
      end
      RD_REQ: begin
        state_d   = RD_DRIVE;
        rd_live_d = 1'b0;
      end
      RD_DRIVE: begin
        if (s_ce_n_q) begin
          state_d = IDLE;
        end else if (!s_we_n_q) begin
          state_d       = WR_HOLD;
          hold_addr_d   = s_addr_q;
          hold_data_d   = s_dq_q;
          hold_byte_n_d = s_byte_n_q;
        end else if (s_oe_n_q || (s_addr_q != rd_addr_q)) begin
          state_d = IDLE;
        end else begin
          // First RD_DRIVE cycle is where mem_rdata lands; capture it at its end.
          if (!rd_live_q) begin
            pad_dq_out_d = mem_rdata;
            rd_live_d    = 1'b1;
          end
          pad_dq_oe_d = lane_oe;
        end
      end
      WR_HOLD: begin
        if (s_we_n_q || s_ce_n_q) begin
          state_d     = WR_COMMIT;
          mem_wen_d   = ~hold_byte_n_q;
          mem_addr_d  = hold_addr_q;
          mem_wdata_d = hold_data_q;
        end else begin
          hold_addr_d   = s_addr_q;
          hold_data_d   = s_dq_q;
          hold_byte_n_d = s_byte_n_q;
        end
      end
      WR_COMMIT: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      m_ce_n_q      <= 1'b1;
      m_we_n_q      <= 1'b1;
      m_oe_n_q      <= 1'b1;
      s_ce_n_q      <= 1'b1;
      s_we_n_q      <= 1'b1;
      s_oe_n_q      <= 1'b1;
      m_byte_n_q    <= '1;
      s_byte_n_q    <= '1;
      m_addr_q      <= '0;
      s_addr_q      <= '0;
      m_dq_q        <= '0;
      s_dq_q        <= '0;
      addr_prev_q   <= '0;
      rd_addr_q     <= '0;
      rd_live_q     <= 1'b0;
      hold_addr_q   <= '0;
      hold_data_q   <= '0;
      hold_byte_n_q <= '0;
      pad_dq_out_q  <= '0;
      pad_dq_oe_q   <= '0;
      mem_addr_q    <= '0;
      mem_ren_q     <= 1'b0;
      mem_wen_q     <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      m_ce_n_q      <= pad_ce_n;
      m_we_n_q      <= pad_we_n;
      m_oe_n_q      <= pad_oe_n;
      s_ce_n_q      <= m_ce_n_q;
      s_we_n_q      <= m_we_n_q;
      s_oe_n_q      <= m_oe_n_q;
      m_byte_n_q    <= pad_byte_n;
      s_byte_n_q    <= m_byte_n_q;
      m_addr_q      <= pad_addr;
      s_addr_q      <= m_addr_q;
      m_dq_q        <= pad_dq_in;
      s_dq_q        <= m_dq_q;
      addr_prev_q   <= s_addr_q;
      rd_addr_q     <= rd_addr_d;
      rd_live_q     <= rd_live_d;
      hold_addr_q   <= hold_addr_d;
      hold_data_q   <= hold_data_d;
      hold_byte_n_q <= hold_byte_n_d;
      pad_dq_out_q  <= pad_dq_out_d;
      pad_dq_oe_q   <= pad_dq_oe_d;
      mem_addr_q    <= mem_addr_d;
      mem_ren_q     <= mem_ren_d;
      mem_wen_q     <= mem_wen_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign pad_dq_out = pad_dq_out_q;
  assign pad_dq_oe  = pad_dq_oe_q;
  assign mem_addr   = mem_addr_q;
  assign mem_ren    = mem_ren_q;
  assign mem_wen    = mem_wen_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
